// File: rtl/sha256_round_core.sv
// Purpose : SHA-256 compression of one 512-bit block, one round per clock.
// Latency : start accepted at edge E0, done pulses in the cycle after E(ROUNDS) (64 cycles).
// Backpr. : none; start is ignored while busy, outputs hold until the next load or reset.
//
// Ports:
//   clk, rst_n      - rising-edge clock, synchronous active-low reset
//   start           - load request, honoured only when busy=0
//   msg_in[511:0]   - message block, word 0 in msg_in[511:480]
//   h_in[255:0]     - chaining input, a in h_in[255:224] ... h in h_in[31:0]
//   busy            - rounds in progress
//   done            - one-cycle pulse, a_out..h_out hold the final round values
//   a_out..h_out    - working variables a..h (live every cycle)
module sha256_round_core #(
    parameter int ROUNDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [511:0] msg_in,
    input  logic [255:0] h_in,
    output logic         busy,
    output logic         done,
    output logic [31:0]  a_out,
    output logic [31:0]  b_out,
    output logic [31:0]  c_out,
    output logic [31:0]  d_out,
    output logic [31:0]  e_out,
    output logic [31:0]  f_out,
    output logic [31:0]  g_out,
    output logic [31:0]  h_out
);

    // Round constant ROM, entry 0 first.
    localparam logic [0:63][31:0] K_TAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [5:0]  t;
    logic [31:0] w [16];   // schedule window; slot 0 is W[t]

    logic [31:0] k_t;
    logic [31:0] ch;
    logic [31:0] maj;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_next;

    always_comb begin
        k_t    = K_TAB[t];
        ch     = (e_out & f_out) ^ (~e_out & g_out);
        maj    = (a_out & b_out) ^ (a_out & c_out) ^ (b_out & c_out);
        t1     = h_out + big_sig1(e_out) + ch + k_t + w[0];
        t2     = big_sig0(a_out) + maj;
        // Computed every round; only consumed once it reaches slot 0 (t >= 16).
        w_next = small_sig1(w[14]) + w[9] + small_sig0(w[1]) + w[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            t     <= '0;
            a_out <= '0;
            b_out <= '0;
            c_out <= '0;
            d_out <= '0;
            e_out <= '0;
            f_out <= '0;
            g_out <= '0;
            h_out <= '0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    a_out <= h_in[255:224];
                    b_out <= h_in[223:192];
                    c_out <= h_in[191:160];
                    d_out <= h_in[159:128];
                    e_out <= h_in[127:96];
                    f_out <= h_in[95:64];
                    g_out <= h_in[63:32];
                    h_out <= h_in[31:0];
                    for (int i = 0; i < 16; i++) begin
                        w[i] <= msg_in[511 - 32*i -: 32];
                    end
                    t    <= '0;
                    busy <= 1'b1;
                end
            end else begin
                h_out <= g_out;
                g_out <= f_out;
                f_out <= e_out;
                e_out <= d_out + t1;
                d_out <= c_out;
                c_out <= b_out;
                b_out <= a_out;
                a_out <= t1 + t2;
                for (int i = 0; i < 15; i++) begin
                    w[i] <= w[i+1];
                end
                w[15] <= w_next;
                if (t == LAST_T) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    t    <= '0;
                end else begin
                    t <= t + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_round_core.sv
module tb_sha256_round_core;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [511:0] msg_in;
    logic [255:0] h_in;
    logic         busy;
    logic         done;
    logic [31:0]  a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out;

    sha256_round_core #(.ROUNDS(64)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .msg_in (msg_in),
        .h_in   (h_in),
        .busy   (busy),
        .done   (done),
        .a_out  (a_out),
        .b_out  (b_out),
        .c_out  (c_out),
        .d_out  (d_out),
        .e_out  (e_out),
        .f_out  (f_out),
        .g_out  (g_out),
        .h_out  (h_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [255:0] ABC_DIG = {
        32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
        32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    localparam logic [255:0] TWO_DIG = {
        32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
        32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    localparam logic [511:0] ABC_MSG = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK2 = {480'h0, 32'h000001c0};

    int n_chk;
    int n_pass;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [255:0] outs();
        return {a_out, b_out, c_out, d_out, e_out, f_out, g_out, h_out};
    endfunction

    // Word-wise mod 2^32 addition of two a..h vectors.
    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = x[32*i +: 32] + y[32*i +: 32];
        end
        return r;
    endfunction

    // Loads one block and runs 80 cycles. After cycle i the round counter is i,
    // so setting start there targets round t=i. Records the first done cycle,
    // the number of done pulses and the outputs seen in the first done cycle.
    task automatic run_block(input logic [511:0] m, input logic [255:0] hv,
                             input int poke_a, input int poke_b,
                             output int lat, output int ndone, output logic [255:0] res);
        msg_in = m;
        h_in   = hv;
        start  = 1'b1;
        step();
        start  = 1'b0;
        chk("load_busy", {255'h0, busy}, 256'h1);
        chk("load_regs", outs(), hv);
        lat   = 0;
        ndone = 0;
        res   = '0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = i;
                    res = outs();
                end
            end
            start = (i == poke_a) || (i == poke_b);
        end
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int           lat;
        int           nd;
        int           cnt;
        int           first_done;
        int           last_done;
        int           gap_bad;
        int           low_cnt;
        logic [255:0] res;
        logic [255:0] h2;

        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        msg_in = '0;
        h_in   = '0;
        step();
        step();
        chk("rst_busy", {255'h0, busy}, 256'h0);
        chk("rst_done", {255'h0, done}, 256'h0);
        chk("rst_outs", outs(), 256'h0);
        rst_n = 1'b1;
        step();

        // Scenario 1: "abc" block from the IV.
        run_block(ABC_MSG, IV, -1, -1, lat, nd, res);
        chk("abc_latency", 256'(lat), 256'd64);
        chk("abc_ndone", 256'(nd), 256'd1);
        chk("abc_a_out", {224'h0, res[255:224]}, {224'h0, 32'h506e3058});
        chk("abc_c_out", {224'h0, res[191:160]}, {224'h0, 32'h04d24d6c});
        chk("abc_digest", add8(res, IV), ABC_DIG);
        chk("abc_hold", add8(outs(), IV), ABC_DIG);
        chk("abc_idle_busy", {255'h0, busy}, 256'h0);

        // Scenario 2: start pulses during rounds 10 and 63 must be ignored.
        run_block(ABC_MSG, IV, 10, 63, lat, nd, res);
        chk("ign_latency", 256'(lat), 256'd64);
        chk("ign_ndone", 256'(nd), 256'd1);
        chk("ign_digest", add8(res, IV), ABC_DIG);

        // Scenario 3: reset at t=30 aborts the block.
        msg_in = ABC_MSG;
        h_in   = IV;
        start  = 1'b1;
        step();
        start  = 1'b0;
        for (int i = 1; i <= 30; i++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_busy", {255'h0, busy}, 256'h0);
        chk("abort_done", {255'h0, done}, 256'h0);
        chk("abort_outs", outs(), 256'h0);
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            step();
            if (done) cnt++;
        end
        chk("abort_no_done", 256'(cnt), 256'd0);
        run_block(ABC_MSG, IV, -1, -1, lat, nd, res);
        chk("abort_rerun", add8(res, IV), ABC_DIG);

        // Scenario 4: start held high. Each done cycle doubles as the next load
        // edge, so pulses are 65 cycles apart (load edge + 64 rounds).
        msg_in = ABC_MSG;
        h_in   = IV;
        start  = 1'b1;
        step();
        cnt        = 0;
        first_done = 0;
        last_done  = 0;
        gap_bad    = 0;
        low_cnt    = 0;
        for (int i = 1; i <= 200; i++) begin
            step();
            if (!busy) low_cnt++;
            if (done) begin
                cnt++;
                chk("b2b_digest", add8(outs(), IV), ABC_DIG);
                if (first_done == 0) first_done = i;
                else if (i - last_done != 65) gap_bad++;
                last_done = i;
            end
        end
        chk("b2b_first", 256'(first_done), 256'd64);
        chk("b2b_count", 256'(cnt), 256'd3);
        chk("b2b_gaps", 256'(gap_bad), 256'd0);
        chk("b2b_busy_low", 256'(low_cnt), 256'd3);

        // Scenario 6: reset asserted together with start (block in flight).
        rst_n = 1'b0;
        start = 1'b1;
        step();
        chk("rst_start_busy", {255'h0, busy}, 256'h0);
        chk("rst_start_outs", outs(), 256'h0);
        rst_n = 1'b1;
        start = 1'b0;
        step();
        chk("rst_start_idle", {255'h0, busy}, 256'h0);
        chk("rst_start_noload", outs(), 256'h0);

        // Scenario 5: two-block message chained through the outputs.
        run_block(BLK1, IV, -1, -1, lat, nd, res);
        chk("two_b1_latency", 256'(lat), 256'd64);
        h2 = add8(res, IV);
        run_block(BLK2, h2, -1, -1, lat, nd, res);
        chk("two_b2_latency", 256'(lat), 256'd64);
        chk("two_digest", add8(res, h2), TWO_DIG);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
